// File: rtl/timer_multi_core.sv
// timer_multi_core: CHANNELS independent compare timers. Each channel has its
// own prescaler, compare/duty shadow registers, restart-on-trigger, a PWM
// output and a sticky match flag. All channels share one prescale value.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | channel stopped, counter and prescaler held at 0
// COUNT  | channel running, counter advances on each prescaler tick
module timer_multi_core #(
  parameter int WIDTH           = 32,
  parameter int CHANNELS        = 4,
  parameter int PRESCALER_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHANNELS-1:0]        trigger,
  input  logic [CHANNELS-1:0]        halt,
  input  logic [CHANNELS-1:0]        single_shot,
  input  logic [CHANNELS*WIDTH-1:0]  compare_value,
  input  logic [CHANNELS*WIDTH-1:0]  pwm_duty,
  input  logic [PRESCALER_WIDTH-1:0] prescale_value,
  input  logic [CHANNELS-1:0]        irq_enable,
  input  logic [CHANNELS-1:0]        irq_clear,
  output logic [CHANNELS-1:0]        active,
  output logic [CHANNELS-1:0]        match_occurred,
  output logic [CHANNELS*WIDTH-1:0]  counter,
  output logic [CHANNELS-1:0]        pwm_out,
  output logic [CHANNELS-1:0]        irq_pending,
  output logic                       irq
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_e;

  logic [CHANNELS-1:0] pend_q, pend_d;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_e                     state_q, state_d;
    logic                       mode_q, mode_d;
    logic [WIDTH-1:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]           cmp_q, cmp_d;
    logic [WIDTH-1:0]           duty_q, duty_d;
    logic [PRESCALER_WIDTH-1:0] pcnt_q, pcnt_d;
    logic                       tick;
    logic                       hit;

    assign tick = (state_q == S_COUNT) && (pcnt_q == prescale_value);
    assign hit  = tick && (cnt_q == cmp_q);

    // A match is suppressed when halt or trigger take priority this cycle.
    assign match_occurred[g]          = hit && !halt[g] && !trigger[g];
    assign active[g]                  = (state_q == S_COUNT);
    assign counter[g*WIDTH +: WIDTH]  = cnt_q;
    assign pwm_out[g]                 = (state_q == S_COUNT) && (cnt_q < duty_q);

    // Next-state logic: halt beats trigger beats match beats plain tick.
    // Halt in IDLE only rewrites values that are already 0 there.
    always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      cmp_d   = cmp_q;
      duty_d  = duty_q;
      pcnt_d  = pcnt_q;
      if (halt[g]) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        pcnt_d  = '0;
      end else if (trigger[g]) begin
        state_d = S_COUNT;
        mode_d  = single_shot[g];
        cmp_d   = compare_value[g*WIDTH +: WIDTH];
        duty_d  = pwm_duty[g*WIDTH +: WIDTH];
        cnt_d   = '0;
        pcnt_d  = '0;
      end else if (state_q == S_COUNT) begin
        if (tick) begin
          pcnt_d = '0;
          if (hit) begin
            cnt_d = '0;
            if (mode_q) begin
              state_d = S_IDLE;
            end else begin
              cmp_d  = compare_value[g*WIDTH +: WIDTH];
              duty_d = pwm_duty[g*WIDTH +: WIDTH];
            end
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end else begin
          // Wraps naturally at 2^PRESCALER_WIDTH if prescale_value was lowered.
          pcnt_d = pcnt_q + PRESCALER_WIDTH'(1);
        end
      end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= S_IDLE;
        mode_q  <= 1'b0;
        cnt_q   <= '0;
        cmp_q   <= '0;
        duty_q  <= '0;
        pcnt_q  <= '0;
      end else begin
        state_q <= state_d;
        mode_q  <= mode_d;
        cnt_q   <= cnt_d;
        cmp_q   <= cmp_d;
        duty_q  <= duty_d;
        pcnt_q  <= pcnt_d;
      end
    end
  end

  // Set wins over a coincident clear so a match is never lost.
  assign pend_d      = match_occurred | (pend_q & ~irq_clear);
  assign irq_pending = pend_q;
  assign irq         = |(pend_q & irq_enable);

  // Sticky match flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: tb/tb_timer_multi_core.sv
// Bench for timer_multi_core: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural per-channel model.
module tb_timer_multi_core;
  localparam int W  = 8;
  localparam int CH = 4;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CH-1:0]   trig, halt, ss, en, clr;
  logic [W-1:0]    cv[CH];
  logic [W-1:0]    pd[CH];
  logic [PW-1:0]   psc;
  logic [CH*W-1:0] cv_bus, pd_bus, counter;
  logic [CH-1:0]   active, match, pwm, pend;
  logic            irq;

  always #5 clk = ~clk;

  for (genvar g = 0; g < CH; g++) begin : g_bus
    assign cv_bus[g*W +: W] = cv[g];
    assign pd_bus[g*W +: W] = pd[g];
  end

  timer_multi_core #(.WIDTH(W), .CHANNELS(CH), .PRESCALER_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trig), .halt(halt), .single_shot(ss),
    .compare_value(cv_bus), .pwm_duty(pd_bus), .prescale_value(psc),
    .irq_enable(en), .irq_clear(clr), .active(active), .match_occurred(match),
    .counter(counter), .pwm_out(pwm), .irq_pending(pend), .irq(irq)
  );

  int n_checks = 0;
  int n_err    = 0;

  // behavioural model: one entry per channel
  int m_run[CH], m_ss[CH], m_cnt[CH], m_pc[CH], m_cmp[CH], m_duty[CH], m_pend[CH];

  // values sampled in the most recent cycle()
  logic [CH-1:0]   s_act, s_match, s_pwm, s_pend;
  logic [CH*W-1:0] s_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0; m_ss[c] = 0; m_cnt[c] = 0; m_pc[c] = 0;
      m_cmp[c] = 0; m_duty[c] = 0; m_pend[c] = 0;
    end
  endtask

  task automatic model_start(input int c);
    m_run[c]  = 1;
    m_ss[c]   = int'(ss[c]);
    m_cmp[c]  = int'(cv[c]);
    m_duty[c] = int'(pd[c]);
    m_cnt[c]  = 0;
    m_pc[c]   = 0;
  endtask

  // One clock cycle: inputs are already set; check at the falling edge,
  // advance the model, then release pulse inputs after the rising edge.
  task automatic cycle();
    logic [CH-1:0]   e_act, e_m, e_pwm, e_pend;
    logic [CH*W-1:0] e_cnt;
    int              tk[CH];
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      tk[c]           = (m_run[c] != 0 && m_pc[c] == int'(psc)) ? 1 : 0;
      e_m[c]          = (tk[c] != 0 && m_cnt[c] == m_cmp[c] && !halt[c] && !trig[c]);
      e_act[c]        = (m_run[c] != 0);
      e_pwm[c]        = (m_run[c] != 0 && m_cnt[c] < m_duty[c]);
      e_pend[c]       = (m_pend[c] != 0);
      e_cnt[c*W +: W] = W'(m_cnt[c]);
    end
    chk("active", active, e_act);
    chk("match", match, e_m);
    chk("counter", counter, e_cnt);
    chk("pwm", pwm, e_pwm);
    chk("pending", pend, e_pend);
    chk("irq", irq, |(e_pend & en));
    s_act = active; s_match = match; s_pwm = pwm; s_pend = pend; s_cnt = counter;
    for (int c = 0; c < CH; c++) begin
      m_pend[c] = (e_m[c] || (m_pend[c] != 0 && !clr[c])) ? 1 : 0;
      if (m_run[c] != 0) begin
        if (halt[c]) begin
          m_run[c] = 0; m_cnt[c] = 0; m_pc[c] = 0;
        end else if (trig[c]) begin
          model_start(c);
        end else if (tk[c] != 0) begin
          m_pc[c] = 0;
          if (m_cnt[c] == m_cmp[c]) begin
            m_cnt[c] = 0;
            if (m_ss[c] != 0) m_run[c] = 0;
            else begin
              m_cmp[c]  = int'(cv[c]);
              m_duty[c] = int'(pd[c]);
            end
          end else begin
            m_cnt[c] = m_cnt[c] + 1;
          end
        end else begin
          m_pc[c] = (m_pc[c] + 1) % (1 << PW);
        end
      end else if (trig[c]) begin
        model_start(c);
      end
    end
    @(posedge clk);
    #1;
    trig = '0; halt = '0; clr = '0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nm, first, j;
    int q[$];
    int duties[3];
    int highs_exp[3];
    duties    = '{3, 0, 12};
    highs_exp = '{3, 0, 10};
    trig = '0; halt = '0; ss = '0; en = '0; clr = '0; psc = '0;
    for (int c = 0; c < CH; c++) begin cv[c] = '0; pd[c] = '0; end
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_active", active, 0);
    chk("rst_match", match, 0);
    chk("rst_counter", counter, 0);
    chk("rst_pwm", pwm, 0);
    chk("rst_pending", pend, 0);
    chk("rst_irq", irq, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // single shot, ch0: compare 3, prescale 0
    cv[0] = 8'd3; ss[0] = 1'b1; trig[0] = 1'b1; en[0] = 1'b1;
    cycle();
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("ss_cnt", s_cnt[W-1:0], k);
      chk("ss_match", s_match[0], (k == 3));
      chk("ss_active", s_act[0], 1);
    end
    cycle();
    chk("ss_idle", s_act[0], 0);
    chk("ss_cnt0", s_cnt[W-1:0], 0);
    chk("ss_pend", s_pend[0], 1);

    // prescale, ch1: prescale 2, compare 1, continuous
    psc = 4'd2; cv[1] = 8'd1; pd[1] = 8'd1; ss[1] = 1'b0; trig[1] = 1'b1;
    cycle();
    nm = 0; first = -1;
    for (int t = 1; t <= 12; t++) begin
      cycle();
      if (s_match[1]) begin nm++; if (first < 0) first = t; end
      if (t == 4) chk("psc_cnt_step", s_cnt[2*W-1:W], 1);
      if (t == 6) chk("psc_pend_low", s_pend[1], 0);
      if (t == 7) chk("psc_pend_rise", s_pend[1], 1);
    end
    chk("psc_matches", nm, 2);
    chk("psc_first", first, 6);
    halt[1] = 1'b1; cycle();
    psc = '0;

    // shadow reload, ch2: compare 5 -> 2 mid-period
    cv[2] = 8'd5; ss[2] = 1'b0; trig[2] = 1'b1;
    cycle();
    q = {};
    for (int t = 1; t <= 15; t++) begin
      if (t == 3) cv[2] = 8'd2;
      cycle();
      if (s_match[2]) q.push_back(t);
    end
    chk("shadow_n", q.size(), 4);
    chk("shadow_first", (q.size() > 0) ? q[0] : -1, 6);
    chk("shadow_second", (q.size() > 1) ? q[1] : -1, 9);
    halt[2] = 1'b1; cycle();

    // PWM, ch3: compare 9, duty 3 / 0 / 12
    cv[3] = 8'd9; ss[3] = 1'b0;
    for (int d = 0; d < 3; d++) begin
      pd[3] = W'(duties[d]); trig[3] = 1'b1;
      cycle();
      nm = 0;
      for (int t = 0; t < 10; t++) begin
        cycle();
        if (s_pwm[3]) nm++;
      end
      chk("pwm_highs", nm, highs_exp[d]);
    end
    halt[3] = 1'b1; cycle();

    // collisions, ch0
    ss[0] = 1'b0; cv[0] = 8'd9; trig[0] = 1'b1;
    cycle();
    repeat (5) cycle();
    trig[0] = 1'b1; halt[0] = 1'b1;
    cycle();
    chk("coll_match", s_match[0], 0);
    cycle();
    chk("coll_idle", s_act[0], 0);
    trig[0] = 1'b1; cycle();
    repeat (5) cycle();
    trig[0] = 1'b1;
    cycle();
    chk("restart_cnt5", s_cnt[W-1:0], 5);
    chk("restart_nomatch", s_match[0], 0);
    cycle();
    chk("restart_cnt0", s_cnt[W-1:0], 0);
    chk("restart_active", s_act[0], 1);
    clr[0] = 1'b1; cv[0] = 8'd2; trig[0] = 1'b1;
    cycle();
    cycle();
    cycle();
    clr[0] = 1'b1;
    cycle();
    chk("clr_coll_match", s_match[0], 1);
    chk("clr_coll_pend_before", s_pend[0], 0);
    cycle();
    chk("clr_coll_pend", s_pend[0], 1);
    halt[0] = 1'b1; cycle();

    // all-ones compare, ch1
    cv[1] = 8'hff; ss[1] = 1'b1; trig[1] = 1'b1;
    cycle();
    first = -1;
    for (int t = 1; t <= 257; t++) begin
      cycle();
      if (s_match[1] && first < 0) first = t;
    end
    chk("allones_match", first, 256);
    chk("allones_idle", s_act[1], 0);

    // prescale lowered below current pcnt, ch2
    psc = 4'd9; cv[2] = 8'd1; ss[2] = 1'b0; trig[2] = 1'b1;
    cycle();
    for (int t = 1; t <= 8; t++) cycle();
    psc = 4'd3;
    first = -1;
    for (j = 1; j <= 20; j++) begin
      cycle();
      if (first < 0 && s_cnt[3*W-1:2*W] == 8'd1) first = j;
    end
    chk("psc_wrap", first, 13);
    halt[2] = 1'b1; cycle();
    psc = '0;

    // randomized traffic on all channels
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0)
        psc = ($urandom_range(0, 3) == 0) ? PW'($urandom_range(0, 15)) : PW'($urandom_range(0, 2));
      if ($urandom_range(0, 49) == 0) en = CH'($urandom_range(0, 15));
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 19) == 0)
          cv[c] = ($urandom_range(0, 15) == 0) ? 8'hff : W'($urandom_range(0, 12));
        if ($urandom_range(0, 19) == 0) pd[c] = W'($urandom_range(0, 14));
        if ($urandom_range(0, 24) == 0) clr[c] = 1'b1;
        if (m_run[c] == 0) begin
          if ($urandom_range(0, 29) == 0) begin
            trig[c] = 1'b1; ss[c] = $urandom_range(0, 1) != 0;
          end
        end else begin
          if ($urandom_range(0, 59) == 0) begin
            trig[c] = 1'b1; ss[c] = $urandom_range(0, 1) != 0;
          end
          if ($urandom_range(0, 99) == 0) halt[c] = 1'b1;
        end
      end
      cycle();
    end

    // reset asserted mid-count
    psc = '0; en = '1;
    for (int c = 0; c < CH; c++) begin cv[c] = 8'd20; pd[c] = 8'd10; end
    trig = '1; ss = '0;
    cycle();
    repeat (5) cycle();
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_active", active, 0);
    chk("midrst_match", match, 0);
    chk("midrst_counter", counter, 0);
    chk("midrst_pwm", pwm, 0);
    chk("midrst_pending", pend, 0);
    chk("midrst_irq", irq, 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
